display_fb_reader: RTL and testbench
====================================

// Module: display_fb_reader
// PURPOSE
//  Scan-out side of the double-buffered frame buffer. Reads the completed buffer from SDRAM through the
//  shared request interface as read requests (wr=0), buffers pixels in a local FIFO and delivers them
//  to the LCD timing generator on demand. Owns stat: it latches swap at each frame start so the sample
//  renderer only starts drawing a new frame once the previous one is on screen.
// PARAMETERS
//  BASE   24'h000000  SDRAM word address of frame buffer 0; buffer 1 at BASE+24'h080000
//  W      800         pixels per line (16-bit RGB565 words)
//  H      480         lines per frame
//  DEPTH  64          pixel FIFO entries (power of 2, >= 4)
// PORTS
//  clkSYS    in   1   system clock; all logic is single-clock
//  n_reset   in   1   reset
//  frame     in   1   1-cycle pulse: start of a new display frame (from LCD timing)
//  swap      in   1   renderer's buffer select
//  stat      out  1   buffer currently being scanned out
//  addr      out  24  request word address
//  req       out  1   request valid; held with addr stable until ack
//  wr        out  1   constant 0 (read)
//  ack       in   1   1-cycle: request accepted by arbiter
//  mem       in   16  read data
//  valid     in   1   1-cycle: mem holds data for the oldest outstanding acked read (in order)
//  pix_rd    in   1   pop one pixel (LCD active area)
//  pix       out  16  pixel for the current pix_rd, registered, valid the cycle after pix_rd
//  underrun  out  1   sticky: pix_rd seen with FIFO empty; cleared at frame
// BEHAVIOUR
//  Reset n_reset: asynchronous, active-low; clock clkSYS. Reset values: stat=0, req=0, addr=BASE,
//   pix=0, underrun=0. FIFO empty, counters 0, state Idle. Reset mid-frame aborts all in-flight reads;
//   a valid arriving after reset is ignored because outstanding=0.
//  States: Idle -> Fetch on frame; Fetch -> Done when W*H requests acked; Done -> Fetch on frame.
//   frame in any state restarts the frame.
//  On frame: stat<=swap; pixcnt<=0; FIFO flushed; discard<=outstanding (+1 if ack same cycle);
//   underrun<=0. Reads belonging to the old frame are dropped while discard>0 (discard decrements per valid).
//  Address: addr = BASE + (stat ? 24'h080000 : 0) + pixcnt, where pixcnt is 24 bits and counts 0..W*H-1.
//   stat is used after its update, so the first request of a frame already targets the new buffer.
//  Request: in Fetch, req<=1 when ~req & ~ack & (fifo_count + outstanding < DEPTH) & pixcnt < W*H.
//   On ack: req<=0 the same edge, pixcnt++, outstanding++. Min 1 idle cycle between requests.
//   req is never asserted in Idle or Done. req stays 0 on the frame-pulse cycle.
//  Data: valid with discard=0 pushes mem into FIFO and decrements outstanding. Credit accounting
//   guarantees no overflow; an overflow is an assertion failure.
//  Simultaneous ack & valid: outstanding unchanged. Valid with outstanding=0 is ignored.
//  Output: pix_rd & ~empty -> pix<=FIFO head, pop. pix_rd & empty -> pix<=0, underrun<=1, no pop.
//   Push and pop in the same cycle are allowed; when the FIFO is full, count stays full.
//  FIFO pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
//  Throughput bound: one request per 2 cycles; the LCD must pop at <= 1/2 clkSYS rate on average.
// TESTING
//  1. Reset, swap=1, frame pulse -> stat=1, first addr=BASE+24'h080000, W=16,H=2: exactly 32 acks,
//     then Done, req=0.
//  2. Arbiter acks after 3 cycles, valid 4 cycles later with mem=addr[15:0]; pix_rd every 2 cycles ->
//     pix sequence 0..31 matches, underrun=0.
//  3. pix_rd stalled -> requests stop when fifo_count+outstanding=DEPTH; no overflow; resume after pop.
//  4. frame pulse with 5 reads outstanding, swap toggled -> next 5 valids dropped, first pixel
//     from the new buffer, stat updated.
//  5. pix_rd with empty FIFO -> pix=0, underrun=1 held until next frame.
//  6. n_reset low mid-Fetch -> all outputs at reset values; late valids ignored; clean restart on frame.

Source files
------------

// File: rtl/display_fb_reader.sv
// display_fb_reader: scan-out reader that streams the displayed frame buffer from SDRAM to the LCD
// Ports:
//   clkSYS, n_reset       system clock, asynchronous active-low reset
//   frame                 1-cycle start-of-frame pulse from LCD timing
//   swap / stat           renderer buffer select / buffer latched for scan-out at frame start
//   addr, req, wr, ack    read request to the SDRAM arbiter (wr is always 0)
//   mem, valid            in-order read data returned for acked requests
//   pix_rd, pix           pixel pop and registered pixel (valid the cycle after pix_rd)
//   underrun              sticky flag: pop attempted on an empty FIFO, cleared at frame
module display_fb_reader #(
    parameter logic [23:0] BASE = 24'h000000,
    parameter int W = 800,
    parameter int H = 480,
    parameter int DEPTH = 64
) (
    input  logic        clkSYS,
    input  logic        n_reset,
    input  logic        frame,
    input  logic        swap,
    output logic        stat,
    output logic [23:0] addr,
    output logic        req,
    output logic        wr,
    input  logic        ack,
    input  logic [15:0] mem,
    input  logic        valid,
    input  logic        pix_rd,
    output logic [15:0] pix,
    output logic        underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [23:0] NPIX = 24'(W * H);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t state, state_n;
    logic [23:0] pixcnt;
    logic [CW-1:0] cnt, outstanding;
    logic [15:0] discard;
    logic [AW-1:0] wp, rp;
    logic [15:0] fifo [DEPTH];
    logic acc, take, fresh, push, pop, room, req_n;

    assign wr = 1'b0;
    assign addr = BASE + (stat ? 24'h080000 : 24'h000000) + pixcnt;
    assign acc = ack & req;
    // any valid while reads are in flight is consumed; old-frame reads come back first and are dropped
    assign take = valid & ((discard != 16'd0) | (outstanding != '0));
    assign fresh = take & (discard == 16'd0);
    assign push = fresh & ~frame;
    assign pop = pix_rd & (cnt != '0);
    // credit: never have more data buffered plus in flight than the FIFO can hold
    assign room = (cnt + outstanding) < CW'(DEPTH);

    always_comb begin
        state_n = frame ? FETCH : (state == FETCH && acc && pixcnt == NPIX - 24'd1) ? DONE : state;
        req_n = ~frame & (req ? ~acc : (state == FETCH) & ~ack & room & (pixcnt < NPIX));
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            req <= 1'b0;
        end else begin
            state <= state_n;
            req <= req_n;
        end
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            stat <= 1'b0;
            pixcnt <= 24'd0;
            outstanding <= '0;
            discard <= 16'd0;
            cnt <= '0;
            wp <= '0;
            rp <= '0;
            pix <= 16'd0;
            underrun <= 1'b0;
        end else begin
            stat <= frame ? swap : stat;
            pixcnt <= frame ? 24'd0 : pixcnt + {23'd0, acc};
            outstanding <= frame ? '0 : outstanding + CW'(acc) - CW'(fresh);
            // at frame every read still in flight (including one acked now) becomes a discard
            discard <= frame ? discard + 16'(outstanding) + 16'(acc) - 16'(take)
                             : discard - 16'(take & ~fresh);
            cnt <= frame ? '0 : cnt + CW'(push) - CW'(pop);
            wp <= frame ? '0 : wp + AW'(push);
            rp <= frame ? '0 : rp + AW'(pop);
            pix <= pix_rd ? (pop ? fifo[rp] : 16'd0) : pix;
            underrun <= frame ? 1'b0 : underrun | (pix_rd & ~pop);
        end
    end

    always_ff @(posedge clkSYS) begin
        if (push)
            fifo[wp] <= mem;
    end

    always_ff @(posedge clkSYS) begin
        if (n_reset)
            assert (!(push && !pop && cnt == CW'(DEPTH)));
    end
endmodule

// File: tb/tb_display_fb_reader.sv
// tb_display_fb_reader: directed bench for display_fb_reader with a small SDRAM arbiter model
module tb_display_fb_reader;
    localparam int W = 16;
    localparam int H = 2;
    localparam int DEPTH = 8;

    logic clkSYS = 1'b0, n_reset = 1'b0, frame = 1'b0, swap = 1'b0;
    logic ack = 1'b0, valid = 1'b0, pix_rd = 1'b0;
    logic stat, req, wr, underrun;
    logic [23:0] addr;
    logic [15:0] mem = 16'd0, pix;

    int tests = 0, fails = 0, ack_cnt = 0, base = 0;
    int ack_dly = 3, lat = 4, cyc = 0, w = 0;
    bit tag = 1'b0;

    typedef struct {int due; logic [15:0] d;} rd_t;
    rd_t q[$];

    always #5 clkSYS = ~clkSYS;

    display_fb_reader #(.BASE(24'h000000), .W(W), .H(H), .DEPTH(DEPTH)) dut (
        .clkSYS(clkSYS), .n_reset(n_reset), .frame(frame), .swap(swap), .stat(stat),
        .addr(addr), .req(req), .wr(wr), .ack(ack), .mem(mem), .valid(valid),
        .pix_rd(pix_rd), .pix(pix), .underrun(underrun)
    );

    always @(posedge clkSYS) if (ack) ack_cnt <= ack_cnt + 1;

    // arbiter: ack ack_dly cycles after req, data lat cycles after ack, in order
    // tag mode marks buffer 1 data with bit 15 so the two buffers are distinguishable
    initial forever begin
        @(negedge clkSYS);
        cyc++;
        ack = 1'b0;
        valid = 1'b0;
        if (req) begin
            w++;
            if (w >= ack_dly) begin
                ack = 1'b1;
                w = 0;
                q.push_back(rd_t'{cyc + lat, tag ? {addr[19], addr[14:0]} : addr[15:0]});
            end
        end else
            w = 0;
        if (q.size() > 0 && q[0].due <= cyc) begin
            valid = 1'b1;
            mem = q[0].d;
            void'(q.pop_front());
        end
    end

    task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clkSYS);
    endtask

    task automatic pulse_frame(input logic s);
        frame = 1'b1;
        swap = s;
        @(negedge clkSYS);
        frame = 1'b0;
    endtask

    task automatic pop_chk(input string t, input logic [15:0] exp);
        pix_rd = 1'b1;
        @(negedge clkSYS);
        pix_rd = 1'b0;
        chk(t, 32'(pix), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clkSYS);
        chk("rst_stat", 32'(stat), 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_pix", 32'(pix), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_wr", 32'(wr), 0);
        n_reset = 1'b1;
        cycles(3);
        chk("idle_no_req", 32'(req), 0);

        // frame into buffer 1, stream 32 pixels
        base = ack_cnt;
        pulse_frame(1'b1);
        chk("t1_stat", 32'(stat), 1);
        for (int k = 0; k < 20 && !req; k++) @(negedge clkSYS);
        chk("t1_req", 32'(req), 1);
        chk("t1_first_addr", 32'(addr), 32'h080000);
        cycles(40);
        for (int i = 0; i < 32; i++) begin
            pop_chk($sformatf("t2_pix%0d", i), 16'(i));
            cycles(3);
        end
        cycles(10);
        chk("t1_acks", 32'(ack_cnt - base), 32);
        chk("t1_done_req", 32'(req), 0);
        chk("t2_underrun", 32'(underrun), 0);

        // stalled consumer: credit limit at DEPTH
        base = ack_cnt;
        pulse_frame(1'b0);
        chk("t3_stat", 32'(stat), 0);
        cycles(80);
        chk("t3_acks_cap", 32'(ack_cnt - base), DEPTH);
        chk("t3_req_stop", 32'(req), 0);
        pop_chk("t3_pix0", 16'h0000);
        cycles(20);
        chk("t3_acks_resume", 32'(ack_cnt - base), DEPTH + 1);
        chk("t3_req_stop2", 32'(req), 0);

        // frame with 5 reads outstanding, buffer toggled
        ack_dly = 1000;
        @(negedge clkSYS);
        pulse_frame(1'b0);
        ack_dly = 1;
        lat = 30;
        tag = 1'b1;
        base = ack_cnt;
        for (int k = 0; k < 100 && (ack_cnt - base) < 5; k++) @(negedge clkSYS);
        chk("t4_acks5", 32'(ack_cnt - base), 5);
        pulse_frame(1'b1);
        chk("t4_stat", 32'(stat), 1);
        chk("t4_addr", 32'(addr), 32'h080000);
        cycles(80);
        pop_chk("t4_pix0", 16'h8000);
        cycles(1);
        pop_chk("t4_pix1", 16'h8001);
        chk("t4_underrun", 32'(underrun), 0);

        // underrun on empty FIFO, sticky until frame
        pulse_frame(1'b1);
        pop_chk("t5_pix_zero", 16'h0000);
        chk("t5_underrun", 32'(underrun), 1);
        cycles(5);
        chk("t5_underrun_held", 32'(underrun), 1);
        pulse_frame(1'b1);
        chk("t5_underrun_clr", 32'(underrun), 0);

        // reset mid-fetch, late valids ignored, clean restart
        cycles(6);
        n_reset = 1'b0;
        #1;
        chk("t6_stat", 32'(stat), 0);
        chk("t6_req", 32'(req), 0);
        chk("t6_addr", 32'(addr), 0);
        chk("t6_pix", 32'(pix), 0);
        chk("t6_underrun", 32'(underrun), 0);
        cycles(3);
        n_reset = 1'b1;
        ack_dly = 3;
        lat = 4;
        tag = 1'b0;
        base = ack_cnt;
        cycles(60);
        chk("t6_idle_req", 32'(req), 0);
        chk("t6_idle_acks", 32'(ack_cnt - base), 0);
        pulse_frame(1'b0);
        cycles(40);
        for (int i = 0; i < 8; i++) begin
            pop_chk($sformatf("t6_pix%0d", i), 16'(i));
            cycles(3);
        end
        chk("t6_underrun_end", 32'(underrun), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
